// File: rtl/i2c_bus_scheduler.sv
// Round-robin owner of the shared I2C SDA/SCL pair: grants one sequencer at a time,
// waits for a bus-free interval, pulses its start and aborts it if done never arrives.
module i2c_bus_scheduler #(
    parameter int N_REQ    = 4,
    parameter int BUS_FREE = 500,
    parameter int TIMEOUT  = 200000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done_in,
    input  logic [N_REQ-1:0] err_in,
    input  logic             scl_in,
    input  logic             sda_in,
    input  logic             err_clear,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] start,
    output logic             busy,
    output logic             timeout_pulse,
    output logic [N_REQ-1:0] err_flags
);

    localparam int PTR_W  = $clog2(N_REQ);
    localparam int FREE_W = $clog2(BUS_FREE + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ARM, START, ACTIVE} state_t;

    state_t            state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  winner;
    logic [FREE_W-1:0] free_cnt;
    logic [TO_W-1:0]   to_cnt;

    logic [PTR_W-1:0]  pick;
    logic              lines_high;
    logic              win_req;
    logic              win_done;
    logic              win_err;
    logic              to_expire;
    logic [N_REQ-1:0]  err_set;

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
        return (w == PTR_W'(N_REQ - 1)) ? '0 : w + 1'b1;
    endfunction

    // First set request at or above base, wrapping past the top index.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [PTR_W-1:0] base);
        logic [PTR_W-1:0] sel;
        logic             hit;
        int               idx;
        sel = base;
        hit = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(base) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!hit && r[PTR_W'(idx)]) begin
                sel = PTR_W'(idx);
                hit = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick       = rr_pick(req, rr_ptr);
    assign lines_high = scl_in & sda_in;
    assign win_req    = req[winner];
    assign win_done   = done_in[winner];
    assign win_err    = err_in[winner];
    // A done arriving on the expiry cycle wins over the timeout.
    assign to_expire  = (state == ACTIVE) && !win_done && (to_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        err_set = '0;
        if (state == ACTIVE) begin
            if ((win_done && win_err) || to_expire) err_set = onehot(winner);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            winner        <= '0;
            free_cnt      <= '0;
            to_cnt        <= '0;
            grant         <= '0;
            start         <= '0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
            err_flags     <= '0;
        end else begin
            start         <= '0;
            timeout_pulse <= 1'b0;
            // Set beats clear on the same bit; other bits still clear.
            err_flags     <= (err_clear ? '0 : err_flags) | err_set;
            case (state)
                IDLE: begin
                    if (|req) begin
                        winner   <= pick;
                        grant    <= onehot(pick);
                        free_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ARM;
                    end
                end
                ARM: begin
                    if (!win_req) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (lines_high) begin
                        if (free_cnt == FREE_W'(BUS_FREE - 1)) state <= START;
                        else free_cnt <= free_cnt + 1'b1;
                    end else begin
                        free_cnt <= '0;
                    end
                end
                START: begin
                    start  <= onehot(winner);
                    to_cnt <= '0;
                    state  <= ACTIVE;
                end
                ACTIVE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (win_done || to_expire) begin
                        grant         <= '0;
                        busy          <= 1'b0;
                        rr_ptr        <= next_ptr(winner);
                        timeout_pulse <= to_expire;
                        state         <= IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// Directed bench for i2c_bus_scheduler with N_REQ=4, BUS_FREE=8, TIMEOUT=100.
module tb_i2c_bus_scheduler;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] done_in = '0;
    logic [3:0] err_in = '0;
    logic       scl_in = 1'b1;
    logic       sda_in = 1'b1;
    logic       err_clear = 1'b0;
    logic [3:0] grant;
    logic [3:0] start;
    logic       busy;
    logic       timeout_pulse;
    logic [3:0] err_flags;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_bus_scheduler #(.N_REQ(4), .BUS_FREE(8), .TIMEOUT(100)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .done_in(done_in), .err_in(err_in),
        .scl_in(scl_in), .sda_in(sda_in), .err_clear(err_clear), .grant(grant),
        .start(start), .busy(busy), .timeout_pulse(timeout_pulse), .err_flags(err_flags)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic wait_start(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (start == 4'b0000 && cyc < limit);
    endtask

    task automatic wait_grant(input int limit);
        int k;
        k = 0;
        while (grant == 4'b0000 && k < limit) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic do_reset();
        req = '0; done_in = '0; err_in = '0; err_clear = 1'b0; sda_in = 1'b1; scl_in = 1'b1;
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(2);
        n_checks++;
        if ({grant, start, busy, timeout_pulse, err_flags} !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got grant=%b start=%b busy=%b to=%b err=%b, want all zero",
                     grant, start, busy, timeout_pulse, err_flags);
        end
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_single();
        int cyc;
        req = 4'b0001;
        step(1);
        n_checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got grant=%b busy=%b, want 0001 1", grant, busy);
        end
        wait_start(40, cyc);
        n_checks++;
        if (cyc != 9 || start !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_start_latency: got %0d cycles start=%b, want 9 cycles 0001", cyc, start);
        end
        step(1);
        n_checks++;
        if (start !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_start_width: got start=%b, want 0000", start);
        end
        step(3);
        done_in = 4'b0001;
        req = 4'b0000;
        step(1);
        done_in = 4'b0000;
        n_checks++;
        if (grant !== 4'b0000 || err_flags !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got grant=%b err=%b busy=%b, want 0000 0000 0", grant, err_flags, busy);
        end
    endtask

    task automatic test_bus_free();
        int cyc;
        req = 4'b0010;
        step(1);
        n_checks++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL busfree_grant: got %b, want 0010", grant);
        end
        step(4);
        sda_in = 1'b0;
        step(1);
        sda_in = 1'b1;
        wait_start(40, cyc);
        n_checks++;
        if (cyc != 9 || start !== 4'b0010) begin
            n_fail++;
            $display("FAIL busfree_restart: got %0d cycles after release start=%b, want 9 0010", cyc, start);
        end
        step(2);
        done_in = 4'b0010;
        req = 4'b0000;
        step(1);
        done_in = 4'b0000;
        step(1);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_order [4];
        int cyc;
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010;
        exp_order[2] = 4'b1000; exp_order[3] = 4'b0001;
        do_reset();
        req = 4'b1011;
        for (int t = 0; t < 4; t++) begin
            wait_grant(10);
            n_checks++;
            if (grant !== exp_order[t]) begin
                n_fail++;
                $display("FAIL rr_order_%0d: got %b, want %b", t, grant, exp_order[t]);
            end
            wait_start(40, cyc);
            for (int i = 0; i < 19; i++) begin
                if (i == 9) begin
                    done_in = ~exp_order[t];
                    err_in  = ~exp_order[t];
                end else begin
                    done_in = 4'b0000;
                    err_in  = 4'b0000;
                end
                step(1);
            end
            n_checks++;
            if (grant !== exp_order[t] || err_flags !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_foreign_done_%0d: got grant=%b err=%b, want %b 0000",
                         t, grant, err_flags, exp_order[t]);
            end
            done_in = exp_order[t];
            step(1);
            done_in = 4'b0000;
            n_checks++;
            if (grant !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_release_%0d: got %b, want 0000", t, grant);
            end
        end
        req = 4'b0000;
        step(2);
    endtask

    task automatic test_timeout_abandon();
        int cyc;
        do_reset();
        req = 4'b0100;
        step(1);
        wait_start(40, cyc);
        step(99);
        n_checks++;
        if (timeout_pulse !== 1'b0 || grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL timeout_early: got pulse=%b grant=%b, want 0 0100", timeout_pulse, grant);
        end
        step(1);
        n_checks++;
        if (timeout_pulse !== 1'b1 || err_flags !== 4'b0100 || grant !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: got pulse=%b err=%b grant=%b busy=%b, want 1 0100 0000 0",
                     timeout_pulse, err_flags, grant, busy);
        end
        req = 4'b0000;
        step(1);
        n_checks++;
        if (timeout_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_width: got %b, want 0", timeout_pulse);
        end
        req = 4'b1001;
        step(1);
        n_checks++;
        if (grant !== 4'b1000) begin
            n_fail++;
            $display("FAIL timeout_next_ptr: got %b, want 1000", grant);
        end
        step(3);
        req = 4'b0000;
        step(1);
        n_checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abandon_arm: got grant=%b busy=%b, want 0000 0", grant, busy);
        end
        req = 4'b1001;
        step(1);
        n_checks++;
        if (grant !== 4'b1000) begin
            n_fail++;
            $display("FAIL abandon_ptr_kept: got %b, want 1000", grant);
        end
        req = 4'b0000;
        step(2);
    endtask

    task automatic test_err_clear();
        int cyc;
        do_reset();
        req = 4'b0010;
        step(1);
        wait_start(40, cyc);
        step(2);
        done_in = 4'b0010;
        err_in  = 4'b0010;
        req     = 4'b0000;
        step(1);
        done_in = 4'b0000;
        err_in  = 4'b0000;
        n_checks++;
        if (err_flags !== 4'b0010 || grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL err_nak: got err=%b grant=%b, want 0010 0000", err_flags, grant);
        end
        req = 4'b0100;
        step(1);
        wait_start(40, cyc);
        step(99);
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        n_checks++;
        if (timeout_pulse !== 1'b1 || err_flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL err_clear_vs_set: got pulse=%b err=%b, want 1 0100", timeout_pulse, err_flags);
        end
        req = 4'b0000;
        step(1);
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        n_checks++;
        if (err_flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL err_clear_all: got %b, want 0000", err_flags);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        req = 4'b0001;
        step(1);
        wait_start(40, cyc);
        step(3);
        n_checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_setup: got grant=%b busy=%b, want 0001 1", grant, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_async: got grant=%b busy=%b, want 0000 0", grant, busy);
        end
        req = 4'b0000;
        step(1);
        reset_n = 1'b1;
        step(1);
    endtask

    initial begin
        step(1);
        test_reset();
        test_single();
        test_bus_free();
        test_round_robin();
        test_timeout_abandon();
        test_err_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
